// File: rtl/xyolo_out_pack_pkg.sv
// Shared definitions for the xyolo output packing stage: FSM state encoding
// and the default lane/word/buffer geometry.
package xyolo_out_pack_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    localparam int DEF_OUT_W      = 16;
    localparam int DEF_PACK_N     = 4;
    localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/xyolo_out_fifo.sv
// Synchronous word buffer for the output stream. The head entry is read
// straight from the storage registers, so a word is visible (and stable)
// the cycle after it is pushed. Push and pop may coincide when full.
module xyolo_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         one
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en, rd_en;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        rd_en    = pop && (cnt_q != '0);
        wr_en    = push && ((cnt_q != FULL_CNT) || rd_en);
        mem_d    = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
        end
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en && !rd_en) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!wr_en && rd_en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State registers; reset empties the buffer and zeroes the head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign one   = (cnt_q == CW'(1));

endmodule

// File: rtl/xyolo_out_pack.sv
// Output packing stage: narrows each datapath result to OUT_W bits, packs
// PACK_N of them per word, buffers words and streams them out with a
// lane mask and an end-of-layer marker.
// Build option: define XYOLO_OUT_SAT_EN for signed saturation instead of
// truncation when narrowing.
module xyolo_out_pack
    import xyolo_out_pack_pkg::*;
#(
    parameter int DATAPATH_W = 32,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int PACK_N     = DEF_PACK_N,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [CNT_W-1:0]        len,
    input  logic                    in_valid,
    input  logic [DATAPATH_W-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PACK_N*OUT_W-1:0] out_data,
    output logic [PACK_N-1:0]       out_strb,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);
    localparam int LW = $clog2(PACK_N);
    localparam int WW = PACK_N * OUT_W;
    localparam int FW = 1 + PACK_N + WW;

    state_e           state_q, state_d;
    logic [LW-1:0]    lane_cnt_q, lane_cnt_d;
    logic [CNT_W-1:0] rcv_cnt_q, rcv_cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WW-1:0]    pack_q, pack_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic [OUT_W-1:0] narrow;
    logic [WW-1:0]    word;
    logic [PACK_N-1:0] strb;
    logic             is_final;
    logic             push, pop;
    logic             fifo_full, fifo_empty, fifo_one;
    logic [FW-1:0]    fifo_dout;

`ifdef XYOLO_OUT_SAT_EN
    localparam logic signed [DATAPATH_W-1:0] SAT_MAX =
        {{(DATAPATH_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [DATAPATH_W-1:0] SAT_MIN =
        {{(DATAPATH_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Clamp the signed result into the OUT_W signed range.
    always_comb begin
        if ($signed(in_data) > SAT_MAX) begin
            narrow = SAT_MAX[OUT_W-1:0];
        end else if ($signed(in_data) < SAT_MIN) begin
            narrow = SAT_MIN[OUT_W-1:0];
        end else begin
            narrow = in_data[OUT_W-1:0];
        end
    end
`else
    logic unused_in_hi;
    assign unused_in_hi = ^in_data[DATAPATH_W-1:OUT_W];

    // Keep the low OUT_W bits of the result.
    always_comb begin
        narrow = in_data[OUT_W-1:0];
    end
`endif

    // Control FSM, lane packing, counters and sticky flags.
    always_comb begin
        word = pack_q;
        word[lane_cnt_q*OUT_W +: OUT_W] = narrow;
        for (int unsigned i = 0; i < PACK_N; i++) begin
            strb[i] = (LW'(i) <= lane_cnt_q);
        end
        is_final   = (rcv_cnt_q == len_q - 1'b1);
        pop        = !fifo_empty && out_ready;
        push       = 1'b0;
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        rcv_cnt_d  = rcv_cnt_q;
        len_d      = len_q;
        pack_d     = pack_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    if (len != '0) begin
                        state_d    = ACTIVE;
                        lane_cnt_d = '0;
                        rcv_cnt_d  = '0;
                        pack_d     = '0;
                        len_d      = len;
                        overflow_d = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (in_valid) begin
                    rcv_cnt_d = rcv_cnt_q + 1'b1;
                    if ((lane_cnt_q == LW'(PACK_N - 1)) || is_final) begin
                        push       = 1'b1;
                        pack_d     = '0;
                        lane_cnt_d = '0;
                        if (fifo_full && !pop) begin
                            overflow_d = 1'b1;
                        end
                        if (is_final) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        pack_d     = word;
                        lane_cnt_d = lane_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Leave on the edge that pops the last buffered word so done
                // lands in the cycle right after that transfer.
                if (fifo_empty || (fifo_one && pop)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            rcv_cnt_q  <= '0;
            len_q      <= '0;
            pack_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            rcv_cnt_q  <= rcv_cnt_d;
            len_q      <= len_d;
            pack_q     <= pack_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    xyolo_out_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({is_final, strb, word}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .one   (fifo_one)
    );

    assign out_valid = !fifo_empty;
    assign out_last  = fifo_dout[FW-1];
    assign out_strb  = fifo_dout[WW +: PACK_N];
    assign out_data  = fifo_dout[WW-1:0];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_xyolo_out_pack.sv
// Self-checking bench for xyolo_out_pack. Expected words come from a
// behavioural model that groups inputs PACK_N at a time; honours the
// XYOLO_OUT_SAT_EN build option in its narrowing rule.
module tb_xyolo_out_pack;
    localparam int DW    = 32;
    localparam int OUT_W = 16;
    localparam int PACK_N = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 20;
    localparam int WW    = PACK_N * OUT_W;

    typedef struct packed {
        logic              last;
        logic [PACK_N-1:0] strb;
        logic [WW-1:0]     data;
    } word_t;

    logic              clk = 1'b0;
    logic              rst, run, in_valid, out_ready;
    logic [CNT_W-1:0]  len;
    logic [DW-1:0]     in_data;
    logic              out_valid, out_last, busy, done, overflow;
    logic [WW-1:0]     out_data;
    logic [PACK_N-1:0] out_strb;

    always #5 clk = ~clk;

    xyolo_out_pack #(
        .DATAPATH_W (DW),
        .OUT_W      (OUT_W),
        .PACK_N     (PACK_N),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_strb  (out_strb),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    word_t got_q[$];
    word_t exp_q[$];
    int    in_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    done_cnt, done_cyc, last_pop_cyc;
    bit    busy_seen, valid_seen, hold_v;
    word_t hold_w;

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: collects transfers, done pulses, and checks stability
    // of a word that is offered but not taken.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                assert (out_valid === 1'b1 && word_t'({out_last, out_strb, out_data}) === hold_w)
                else begin
                    errors++;
                    $error("FAIL stable: got v=%0b %h want v=1 %h", out_valid,
                           {out_last, out_strb, out_data}, hold_w);
                end
            end
            if (busy) busy_seen = 1'b1;
            if (out_valid) valid_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(word_t'({out_last, out_strb, out_data}));
                last_pop_cyc = cyc;
            end
            hold_v = out_valid && !out_ready;
            hold_w = word_t'({out_last, out_strb, out_data});
        end
    end

    function automatic logic [OUT_W-1:0] narrow_ref(input int x);
        longint v  = x;
        longint hi = (longint'(1) << (OUT_W - 1)) - 1;
        longint lo = -hi - 1;
`ifdef XYOLO_OUT_SAT_EN
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
`else
        if (hi < lo) v = 0;
`endif
        return OUT_W'(v);
    endfunction

    function automatic void build_model(input int n, input bit hold);
        int nw = (n + PACK_N - 1) / PACK_N;
        exp_q.delete();
        for (int w = 0; w < nw; w++) begin
            word_t e;
            e = '0;
            for (int k = 0; k < PACK_N; k++) begin
                int i = w * PACK_N + k;
                if (i < n) begin
                    e.data = e.data | (WW'(narrow_ref(in_q[i])) << (k * OUT_W));
                    e.strb[k] = 1'b1;
                end
            end
            e.last = (w == nw - 1);
            if (!hold || w < DEPTH) exp_q.push_back(e);
        end
    endfunction

    task automatic run_layer(input int n, input bit rnd_ready, input bit gaps,
                             input bit hold, input bit poke_run, input bit ovf_before);
        int idx;
        int guard;
        bit exp_ovf;
        got_q.delete();
        done_cnt = 0; done_cyc = -1; last_pop_cyc = -1;
        busy_seen = 1'b0; valid_seen = 1'b0;
        build_model(n, hold);
        exp_ovf = (n == 0) ? ovf_before : (hold && ((n + PACK_N - 1) / PACK_N > DEPTH));

        @(posedge clk); #1;
        run = 1'b1; len = CNT_W'(n); out_ready = !hold;
        @(posedge clk); #1;
        run = 1'b0; len = CNT_W'($urandom);
        checks++;
        if (n != 0) begin
            assert (busy === 1'b1 && overflow === 1'b0) else begin
                errors++;
                $error("FAIL start: busy=%0b ovf=%0b want busy=1 ovf=0", busy, overflow);
            end
        end else begin
            assert (done === 1'b1 && busy === 1'b0) else begin
                errors++;
                $error("FAIL zero_len: done=%0b busy=%0b want done=1 busy=0", done, busy);
            end
        end

        idx = 0;
        while (idx < n) begin
            if (!gaps || $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1; in_data = in_q[idx]; idx++;
            end else begin
                in_valid = 1'b0; in_data = $urandom;
            end
            if (poke_run && idx == 3) begin
                run = 1'b1; len = CNT_W'(3);
            end else begin
                run = 1'b0;
            end
            if (!hold) out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; run = 1'b0;

        if (n != 0) begin
            checks++;
            assert (out_valid === 1'b1) else begin
                errors++;
                $error("FAIL latency: out_valid=%0b want 1", out_valid);
            end
        end
        if (hold) begin
            checks++;
            assert (overflow === exp_ovf) else begin
                errors++;
                $error("FAIL ovf_hold: got %0b want %0b", overflow, exp_ovf);
            end
        end

        guard = 0;
        while (done_cnt == 0 && guard < 300) begin
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        assert (done_cnt != 0) else begin
            errors++;
            $error("FAIL done_timeout: got no done within %0d cycles, want done", guard);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end

        checks++;
        assert (got_q.size() == exp_q.size()) else begin
            errors++;
            $error("FAIL word_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            assert (got_q[i] === exp_q[i]) else begin
                errors++;
                $error("FAIL word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        assert (done_cnt == 1) else begin
            errors++;
            $error("FAIL done_pulses: got %0d want 1", done_cnt);
        end
        if (exp_q.size() > 0) begin
            checks++;
            assert (done_cyc == last_pop_cyc + 1) else begin
                errors++;
                $error("FAIL done_timing: got cycle %0d want %0d", done_cyc, last_pop_cyc + 1);
            end
        end
        checks++;
        assert (busy === 1'b0 && busy_seen == (n != 0) && valid_seen == (exp_q.size() > 0))
        else begin
            errors++;
            $error("FAIL flags: busy=%0b busy_seen=%0b valid_seen=%0b want 0 %0b %0b",
                   busy, busy_seen, valid_seen, n != 0, exp_q.size() > 0);
        end
        checks++;
        assert (overflow === exp_ovf) else begin
            errors++;
            $error("FAIL ovf_end: got %0b want %0b", overflow, exp_ovf);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; run = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (out_valid === 1'b0 && out_data === '0 && out_strb === '0 && out_last === 1'b0 &&
                busy === 1'b0 && done === 1'b0 && overflow === 1'b0)
        else begin
            errors++;
            $error("FAIL reset: v=%0b d=%h s=%h l=%0b b=%0b dn=%0b o=%0b want all 0",
                   out_valid, out_data, out_strb, out_last, busy, done, overflow);
        end
        rst = 1'b0;

        in_q = '{1, 2, 3, 4};
        run_layer(4, 0, 0, 0, 0, 0);

        in_q = '{1, 2, 3, 4, 5, 6};
        run_layer(6, 0, 0, 0, 0, 0);

        in_q = '{32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFF0, 32'h0000_1234};
        run_layer(4, 0, 0, 0, 0, 0);

        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(4, 30);
            in_q.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) != 0) in_q.push_back(int'($urandom));
                else in_q.push_back(int'($urandom_range(0, 80000)) - 40000);
            end
            run_layer(n, t[0], t[1], 0, 1, 0);
        end

        run_layer(0, 0, 0, 0, 0, 0);

        in_q.delete();
        for (int i = 0; i < 40; i++) in_q.push_back(int'($urandom));
        run_layer(40, 0, 0, 1, 0, 0);

        in_q = '{7, -7, 32'h0000_8000, -32'sd40000, 11};
        run_layer(5, 0, 0, 0, 0, 1);

        // Mid-layer reset with a word still buffered.
        @(posedge clk); #1;
        run = 1'b1; len = CNT_W'(8); out_ready = 1'b0; done_cnt = 0;
        @(posedge clk); #1;
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        assert (out_valid === 1'b1 && busy === 1'b1) else begin
            errors++;
            $error("FAIL pre_reset: v=%0b busy=%0b want 1 1", out_valid, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        assert (out_valid === 1'b0 && out_data === '0 && out_strb === '0 && out_last === 1'b0 &&
                busy === 1'b0 && done === 1'b0 && overflow === 1'b0)
        else begin
            errors++;
            $error("FAIL mid_reset: v=%0b d=%h s=%h l=%0b b=%0b dn=%0b o=%0b want all 0",
                   out_valid, out_data, out_strb, out_last, busy, done, overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        assert (done_cnt == 0) else begin
            errors++;
            $error("FAIL reset_done: got %0d done pulses want 0", done_cnt);
        end

        in_q.delete();
        for (int i = 0; i < 4; i++) in_q.push_back(int'($urandom));
        run_layer(4, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
